lane_dispatcher: RTL

- Schedules substitution-simulation records {pos, nucl_alig, matrix_P} from a valid/ready record stream onto NUM_LANES site-evolution lanes.
- Tracks per-lane busy state from start/done handshakes and picks idle lanes round-robin.
- Drives one shared, registered record bus with a one-hot start strobe.
- Supports a flush that blocks intake until every lane is idle, and keeps issue/completion counters for host readback.

---
 rtl/lane_dispatcher.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/lane_dispatcher.sv
// Dispatches {pos, nucl, matrix} records onto NUM_LANES lanes, round-robin over idle lanes.
// Optional LANE_DISPATCHER_POS_STEER_EN: the record's pos field names the mandatory target lane.
module lane_dispatcher #(
    parameter int unsigned NUM_LANES = 8,
    parameter int unsigned POS_W     = 3,
    parameter int unsigned NUCL_W    = 32,
    parameter int unsigned MAT_W     = 160,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rec_valid,
    input  logic [POS_W+NUCL_W+MAT_W-1:0] rec_data,
    output logic                          rec_ready,
    output logic [NUM_LANES-1:0]          lane_start,
    output logic [NUCL_W-1:0]             disp_nucl,
    output logic [MAT_W-1:0]              disp_matrix,
    output logic [POS_W-1:0]              disp_lane,
    input  logic [NUM_LANES-1:0]          lane_done,
    output logic [NUM_LANES-1:0]          lane_busy,
    input  logic                          flush,
    output logic                          flush_done,
    output logic [CNT_W-1:0]              jobs_issued,
    output logic [CNT_W-1:0]              jobs_done,
    output logic                          err_spurious
);
    typedef enum logic [1:0] {
        RUN        = 2'd0,
        DRAIN      = 2'd1,
        FLUSH_DONE = 2'd2
    } state_e;

    state_e               state_q;
    logic [NUM_LANES-1:0] busy_q;
    logic [NUM_LANES-1:0] start_q;
    logic [NUCL_W-1:0]    nucl_q;
    logic [MAT_W-1:0]     matrix_q;
    logic [POS_W-1:0]     lane_q;
    logic [CNT_W-1:0]     issued_q;
    logic [CNT_W-1:0]     done_cnt_q;
    logic                 flush_done_q;
    logic                 err_q;

    logic [POS_W-1:0]     rec_pos;
    logic [NUCL_W-1:0]    rec_nucl;
    logic [MAT_W-1:0]     rec_matrix;
    logic [POS_W-1:0]     sel;
    logic                 sel_ok;
    logic [NUM_LANES-1:0] sel_oh;
    logic                 accept;
    logic [NUM_LANES-1:0] done_ok;
    logic [NUM_LANES-1:0] busy_clr;
    logic [CNT_W-1:0]     done_inc;

    assign rec_pos    = rec_data[NUCL_W+MAT_W +: POS_W];
    assign rec_nucl   = rec_data[MAT_W +: NUCL_W];
    assign rec_matrix = rec_data[MAT_W-1:0];

`ifdef LANE_DISPATCHER_POS_STEER_EN
    assign sel    = rec_pos;
    assign sel_ok = !busy_q[sel];
`else
    logic [POS_W-1:0] rr_ptr_q;
    logic [POS_W-1:0] idx;
    logic             unused_pos;

    assign unused_pos = ^rec_pos;

    // First idle lane at or above rr_ptr; iterate downward so the nearest one wins.
    always_comb begin
        sel    = rr_ptr_q;
        sel_ok = 1'b0;
        idx    = '0;
        for (int k = int'(NUM_LANES) - 1; k >= 0; k--) begin
            idx = rr_ptr_q + POS_W'(k);
            if (!busy_q[idx]) begin
                sel    = idx;
                sel_ok = 1'b1;
            end
        end
    end
`endif

    assign rec_ready = !reset && (state_q == RUN) && !flush && sel_ok;
    assign accept    = rec_valid && rec_ready;
    assign sel_oh    = NUM_LANES'(1) << sel;
    assign done_ok   = lane_done & busy_q;
    assign busy_clr  = busy_q & ~lane_done;

    always_comb begin
        done_inc = '0;
        for (int i = 0; i < int'(NUM_LANES); i++) begin
            done_inc = done_inc + CNT_W'(done_ok[i]);
        end
    end

    // Lane bookkeeping, dispatch bus and flush FSM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            busy_q       <= '0;
            start_q      <= '0;
            nucl_q       <= '0;
            matrix_q     <= '0;
            lane_q       <= '0;
            issued_q     <= '0;
            done_cnt_q   <= '0;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
`ifndef LANE_DISPATCHER_POS_STEER_EN
            rr_ptr_q     <= '0;
`endif
        end else begin
            start_q      <= accept ? sel_oh : '0;
            busy_q       <= busy_clr | (accept ? sel_oh : '0);
            done_cnt_q   <= done_cnt_q + done_inc;
            flush_done_q <= 1'b0;
            if (|(lane_done & ~busy_q)) begin
                err_q <= 1'b1;
            end
            if (accept) begin
                nucl_q   <= rec_nucl;
                matrix_q <= rec_matrix;
                lane_q   <= sel;
                issued_q <= issued_q + CNT_W'(1);
`ifndef LANE_DISPATCHER_POS_STEER_EN
                rr_ptr_q <= sel + POS_W'(1);
`endif
            end
            case (state_q)
                RUN: begin
                    if (flush) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (busy_clr == '0) begin
                        state_q      <= FLUSH_DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                FLUSH_DONE: begin
                    state_q <= flush ? DRAIN : RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign lane_start   = start_q;
    assign lane_busy    = busy_q;
    assign disp_nucl    = nucl_q;
    assign disp_matrix  = matrix_q;
    assign disp_lane    = lane_q;
    assign jobs_issued  = issued_q;
    assign jobs_done    = done_cnt_q;
    assign flush_done   = flush_done_q;
    assign err_spurious = err_q;

endmodule
